// File: rtl/conv_row_loader.sv
// rtl/conv_row_loader.sv - Raster pixel stream to MESH_W-wide row words via ping-pong buffers.
// Optional top/bottom zero-row framing is enabled by the LOADER_PAD_EN macro.
module conv_row_loader #(
  parameter int MESH_W = 20,
  parameter int MESH_H = 20,
  parameter int DW     = 12
) (
  input  logic                          ck,
  input  logic                          res,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DW-1:0]                 s_data,
  input  logic                          s_last,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [MESH_W*DW-1:0]          row_data,
  output logic [$clog2(MESH_H+2)-1:0]   row_idx,
  output logic                          row_first,
  output logic                          row_last,
  output logic                          frame_done,
  output logic                          err_frame
);

  localparam int CW = (MESH_W > 1) ? $clog2(MESH_W) : 1;
  localparam int FW = (MESH_H > 1) ? $clog2(MESH_H) : 1;
  localparam logic [CW-1:0] COL_END = CW'(MESH_W - 1);
  localparam logic [FW-1:0] ROW_END = FW'(MESH_H - 1);

`ifdef LOADER_PAD_EN
  localparam bit PAD = 1'b1;
  typedef enum logic [1:0] {PADTOP, FILL, ZFILL, PADBOT} state_t;
  localparam state_t ST_INIT  = PADTOP;
  localparam state_t END_NEXT = PADBOT;
  logic zero_all;
`else
  localparam bit PAD = 1'b0;
  typedef enum logic {FILL, ZFILL} state_t;
  localparam state_t ST_INIT  = FILL;
  localparam state_t END_NEXT = FILL;
`endif

  state_t state, state_nxt;
  logic [MESH_W*DW-1:0] rbuf [2];
  logic [1:0] full, tfirst, tlast;
  logic wr_sel, rd_sel, live;
  logic [CW-1:0] col;
  logic [FW-1:0] frow;
  logic acc, fill_end, wr_row, tag_first, tag_last, frame_end, drain;

  assign row_valid = full[rd_sel];
  assign row_data  = rbuf[rd_sel];
  assign row_first = tfirst[rd_sel];
  assign row_last  = tlast[rd_sel];
  assign drain     = full[rd_sel] && row_ready;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    acc       = 1'b0;
    fill_end  = 1'b0;
    wr_row    = 1'b0;
    tag_first = 1'b0;
    tag_last  = 1'b0;
    frame_end = 1'b0;
`ifdef LOADER_PAD_EN
    zero_all  = 1'b0;
`endif
    case (state)
      FILL: begin
        s_ready = live && !full[wr_sel];
        acc     = s_valid && s_ready;
        if (acc) begin
          if (col == COL_END) begin
            wr_row    = 1'b1;
            fill_end  = 1'b1;
            tag_first = !PAD && (frow == '0);
            tag_last  = !PAD && ((frow == ROW_END) || s_last);
            if ((frow == ROW_END) || s_last) begin
              frame_end = 1'b1;
              state_nxt = END_NEXT;
            end
          end else if (s_last) begin
            state_nxt = ZFILL;
          end
        end
      end
      // truncated row: pad the tail with zeros and close the frame in one cycle
      ZFILL: begin
        wr_row    = 1'b1;
        tag_first = !PAD && (frow == '0);
        tag_last  = !PAD;
        frame_end = 1'b1;
        state_nxt = END_NEXT;
      end
`ifdef LOADER_PAD_EN
      PADTOP: begin
        if (live && !full[wr_sel]) begin
          wr_row    = 1'b1;
          zero_all  = 1'b1;
          tag_first = 1'b1;
          state_nxt = FILL;
        end
      end
      PADBOT: begin
        if (!full[wr_sel]) begin
          wr_row    = 1'b1;
          zero_all  = 1'b1;
          tag_last  = 1'b1;
          state_nxt = PADTOP;
        end
      end
`endif
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state      <= ST_INIT;
      live       <= 1'b0;
      rbuf[0]    <= '0;
      rbuf[1]    <= '0;
      full       <= '0;
      tfirst     <= '0;
      tlast      <= '0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      col        <= '0;
      frow       <= '0;
      row_idx    <= '0;
      frame_done <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (acc)
        rbuf[wr_sel][col*DW +: DW] <= s_data;
      if (state == ZFILL) begin
        for (int c = 0; c < MESH_W; c++)
          if (CW'(c) > col)
            rbuf[wr_sel][c*DW +: DW] <= '0;
      end
`ifdef LOADER_PAD_EN
      if (zero_all)
        rbuf[wr_sel] <= '0;
`endif
      if (wr_row) begin
        full[wr_sel]   <= 1'b1;
        tfirst[wr_sel] <= tag_first;
        tlast[wr_sel]  <= tag_last;
        wr_sel         <= ~wr_sel;
      end
      if (fill_end || (state == ZFILL))
        col <= '0;
      else if (acc && !s_last)
        col <= col + 1'b1;
      if (frame_end)
        frow <= '0;
      else if (fill_end)
        frow <= frow + 1'b1;
      // s_last early, or missing/present at the wrong row boundary
      if ((acc && s_last && (col != COL_END)) ||
          (fill_end && ((frow == ROW_END) != s_last)))
        err_frame <= 1'b1;
      if (drain) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        row_idx      <= tlast[rd_sel] ? '0 : row_idx + 1'b1;
      end
      frame_done <= drain && tlast[rd_sel];
    end
  end

endmodule

// File: tb/tb_conv_row_loader.sv
// tb/tb_conv_row_loader.sv - Directed/random bench for conv_row_loader with a row-level reference model.
module tb_conv_row_loader;
  localparam int W  = 20;
  localparam int H  = 20;
  localparam int DW = 12;
  localparam int IW = $clog2(H+2);
`ifdef LOADER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic ck = 1'b0;
  logic res, s_valid, s_ready, s_last, row_valid, row_ready;
  logic row_first, row_last, frame_done, err_frame;
  logic [DW-1:0] s_data;
  logic [W*DW-1:0] row_data;
  logic [IW-1:0] row_idx;

  conv_row_loader #(.MESH_W(W), .MESH_H(H), .DW(DW)) dut (
    .ck(ck), .res(res), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_first(row_first), .row_last(row_last),
    .frame_done(frame_done), .err_frame(err_frame)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [W*DW-1:0] data;
    logic            first;
    logic            last;
    logic [IW-1:0]   idx;
  } row_t;

  row_t exp_q[$];
  logic [DW-1:0] fd_q[$];
  logic          fl_q[$];
  int checks = 0;
  int errors = 0;
  bit exp_fd = 1'b0;
  bit exp_err = 1'b0;
  int rr_mode = 1;
  int sv_mode = 1;
  int pix_acc = 0;

  function automatic void push_row(logic [W*DW-1:0] d, bit f, bit l, int idx);
    row_t r;
    r.data = d; r.first = f; r.last = l; r.idx = IW'(idx);
    exp_q.push_back(r);
  endfunction

  // Queue n pixels (s_last on the final one) and the rows the mesh should see for them.
  task automatic frame(input int n, input bit rnd, input int base);
    logic [DW-1:0] px[$];
    int nrows;
    logic [W*DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      px.push_back(rnd ? DW'($urandom) : DW'(base + i));
      fd_q.push_back(px[i]);
      fl_q.push_back(i == n-1);
    end
    nrows = (n + W - 1) / W;
    for (int r = 0; r < nrows; r++) begin
      d = '0;
      for (int c = 0; c < W; c++)
        if (r*W + c < n) d[c*DW +: DW] = px[r*W + c];
      push_row(d, !PAD && r == 0, !PAD && r == nrows-1, r + int'(PAD));
    end
    if (PAD) begin
      push_row('0, 1'b0, 1'b1, nrows + 1);
      push_row('0, 1'b1, 1'b0, 0);
    end
    if (n != W*H) exp_err = 1'b1;
  endtask

  task automatic step();
    bit rr, sv;
    @(negedge ck);
    checks++;
    assert (frame_done === exp_fd) else begin
      errors++; $error("FAIL frame_done got %0b want %0b", frame_done, exp_fd);
    end
    exp_fd = 1'b0;
    rr = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : rr_mode[0];
    row_ready = rr;
    if (row_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++; $error("FAIL unexpected_row got row_idx %0d want no row", row_idx);
      end
      if (exp_q.size() != 0) begin
        checks += 2;
        assert (row_data === exp_q[0].data) else begin
          errors++; $error("FAIL row_data got %h want %h", row_data, exp_q[0].data);
        end
        assert ({row_first, row_last, row_idx} === {exp_q[0].first, exp_q[0].last, exp_q[0].idx}) else begin
          errors++; $error("FAIL row_tags got f%0b l%0b i%0d want f%0b l%0b i%0d",
                           row_first, row_last, row_idx, exp_q[0].first, exp_q[0].last, exp_q[0].idx);
        end
        if (rr) begin
          exp_fd = exp_q[0].last;
          void'(exp_q.pop_front());
        end
      end
    end
    sv = (sv_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (sv && fd_q.size() != 0) begin
      s_valid = 1'b1; s_data = fd_q[0]; s_last = fl_q[0];
      if (s_ready) begin
        void'(fd_q.pop_front()); void'(fl_q.pop_front()); pix_acc++;
      end
    end else begin
      s_valid = 1'b0; s_data = DW'($urandom); s_last = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fd_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step(); n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++; $error("FAIL drain_timeout got %0d pixels %0d rows left want 0", fd_q.size(), exp_q.size());
    end
    step(); step();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 3;
    assert ({s_ready, row_valid, row_first, row_last, frame_done, err_frame} === 6'b0) else begin
      errors++; $error("FAIL %s_flags got %b want 000000", tag,
                       {s_ready, row_valid, row_first, row_last, frame_done, err_frame});
    end
    assert (row_data === '0) else begin
      errors++; $error("FAIL %s_row_data got %h want 0", tag, row_data);
    end
    assert (row_idx === '0) else begin
      errors++; $error("FAIL %s_row_idx got %0d want 0", tag, row_idx);
    end
  endtask

  task automatic release_reset();
    row_ready = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    exp_q.delete(); fd_q.delete(); fl_q.delete();
    exp_fd = 1'b0; exp_err = 1'b0;
    if (PAD) push_row('0, 1'b1, 1'b0, 0);
    @(negedge ck);
    res = 1'b1;
    #1;
    checks++;
    assert (s_ready === 1'b0) else begin
      errors++; $error("FAIL ready_before_edge got %0b want 0", s_ready);
    end
    @(negedge ck);
    checks++;
    assert (s_ready === !PAD) else begin
      errors++; $error("FAIL ready_edge1 got %0b want %0b", s_ready, !PAD);
    end
    @(negedge ck);
    checks++;
    assert (s_ready === 1'b1) else begin
      errors++; $error("FAIL ready_edge2 got %0b want 1", s_ready);
    end
  endtask

  initial begin
    int base, n;
    res = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; row_ready = 1'b0;
    repeat (3) @(negedge ck);
    check_reset_outputs("reset");
    release_reset();

    // clean frame, sequential pixels, sink always ready
    rr_mode = 1; sv_mode = 1;
    frame(W*H, 1'b0, 0);
    drain(3000);
    checks++;
    assert (err_frame === 1'b0) else begin
      errors++; $error("FAIL err_clean got %0b want 0", err_frame);
    end

    // backpressure: both buffers fill, then the sink releases
    rr_mode = 0;
    base = pix_acc;
    frame(W*H, 1'b0, 0);
    repeat (80) step();
    checks += 2;
    assert (pix_acc - base === 2*W - int'(PAD)*W) else begin
      errors++; $error("FAIL bp_accepted got %0d want %0d", pix_acc - base, 2*W - int'(PAD)*W);
    end
    assert ({s_ready, row_valid} === 2'b01) else begin
      errors++; $error("FAIL bp_handshake got %b want 01", {s_ready, row_valid});
    end
    rr_mode = 1;
    drain(3000);

    // truncated frame: s_last on pixel 5 of row 3
    frame(3*W + 6, 1'b0, 0);
    n = 0;
    while (fd_q.size() != 0 && n < 500) begin
      step(); n++;
    end
    step();
    checks++;
    assert (s_ready === 1'b0) else begin
      errors++; $error("FAIL zfill_ready got %0b want 0", s_ready);
    end
    step();
    checks++;
    assert (s_ready === !PAD) else begin
      errors++; $error("FAIL post_zfill_ready got %0b want %0b", s_ready, !PAD);
    end
    drain(1000);
    checks++;
    assert (err_frame === 1'b1) else begin
      errors++; $error("FAIL err_trunc got %0b want 1", err_frame);
    end
    rr_mode = 2; sv_mode = 2;
    frame(W*H, 1'b1, 0);
    drain(5000);
    checks++;
    assert (err_frame === 1'b1) else begin
      errors++; $error("FAIL err_sticky got %0b want 1", err_frame);
    end

    // reset with 10 pixels of row 2 in flight
    rr_mode = 1; sv_mode = 1;
    base = pix_acc;
    frame(W*H, 1'b0, 0);
    n = 0;
    while (pix_acc - base < 2*W + 10 && n < 500) begin
      step(); n++;
    end
    @(posedge ck);
    #2 res = 1'b0;
    #1 check_reset_outputs("midreset");
    release_reset();
    rr_mode = 2; sv_mode = 2;
    frame(W*H, 1'b1, 0);
    drain(5000);
    checks++;
    assert (err_frame === 1'b0) else begin
      errors++; $error("FAIL err_after_reset got %0b want 0", err_frame);
    end

    frame(W*H, 1'b1, 0);
    drain(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
